// File: rtl/cheri_pkg.sv
// Shared types and constants for the CHERI register-clear sequencer.
// Holds the FSM state enum, quarter geometry and a minimal core config.
package cheri_pkg;

  localparam int REGCLR_QUARTERS = 4;
  localparam int REGCLR_QW       = 8;

  typedef enum logic {
    IDLE,
    CLEAR
  } regclr_state_e;

  typedef struct packed {
    bit CheriPresent;
  } cva6_cfg_t;

  // Default build has capability support enabled.
  localparam cva6_cfg_t cva6_cfg_empty = '{CheriPresent: 1'b1};

endpackage

// File: rtl/cheri_regclr_sequencer_if.sv
// Clear-request handshake between commit and the clear sequencer.
// Commit drives valid/mask; the sequencer returns ready.
interface cheri_regclr_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_mask;

  modport master (
    output req_valid,
    output req_mask,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_mask,
    output req_ready
  );

endinterface

// File: rtl/cheri_regclr_qsel.sv
// Picks the lowest non-empty quarter of a pending clear mask.
// Reports its byte mask, first register and whether it is the last one.
module cheri_regclr_qsel
  import cheri_pkg::*;
(
  input  logic [31:0] pend_i,
  output logic        valid_o,
  output logic [1:0]  quarter_o,
  output logic [7:0]  mask_o,
  output logic [4:0]  waddr_o,
  output logic        last_o
);

  logic [REGCLR_QUARTERS-1:0] nz;
  logic [2:0]                 bit_idx;

  // Priority-select lowest non-empty quarter and its lowest set bit.
  always_comb begin
    nz = '0;
    for (int q = 0; q < REGCLR_QUARTERS; q++) begin
      nz[q] = |pend_i[REGCLR_QW*q +: REGCLR_QW];
    end
    valid_o   = |nz;
    quarter_o = '0;
    for (int q = REGCLR_QUARTERS-1; q >= 0; q--) begin
      if (nz[q]) quarter_o = 2'(q);
    end
    mask_o  = pend_i[REGCLR_QW*quarter_o +: REGCLR_QW];
    bit_idx = '0;
    for (int b = REGCLR_QW-1; b >= 0; b--) begin
      if (mask_o[b]) bit_idx = 3'(b);
    end
    waddr_o = {quarter_o, bit_idx};
    last_o  = (nz & ~(4'b0001 << quarter_o)) == '0;
  end

endmodule

// File: rtl/cheri_regclr_sequencer.sv
// Turns a bulk register-clear mask into quarter-clear regfile writes,
// stealing only cycles where commit port 0 is not writing.
module cheri_regclr_sequencer
  import cheri_pkg::*;
#(
  parameter cva6_cfg_t CVA6Cfg    = cva6_cfg_empty,
  parameter int        DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cheri_regclr_sequencer_if.slave req,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  cm_we_i,
  input  logic [4:0]            cm_waddr_i,
  input  logic [DATA_WIDTH-1:0] cm_wdata_i,
  output logic                  rf_we_o,
  output logic [4:0]            rf_waddr_o,
  output logic [DATA_WIDTH-1:0] rf_wdata_o,
  output logic                  rf_clr_o,
  output logic [7:0]            rf_mask_o,
  output logic [1:0]            rf_quarter_o
);

  localparam bit CHERI = CVA6Cfg.CheriPresent;

  regclr_state_e state_q, state_d;
  logic [31:0]   pend_q, pend_d;
  logic          done_q, done_d;
  logic [31:0]   cap;
  logic          issue;

  logic       q_valid;
  logic [1:0] q_quarter;
  logic [7:0] q_mask;
  logic [4:0] q_waddr;
  logic       q_last;

  cheri_regclr_qsel u_qsel (
    .pend_i    (pend_q),
    .valid_o   (q_valid),
    .quarter_o (q_quarter),
    .mask_o    (q_mask),
    .waddr_o   (q_waddr),
    .last_o    (q_last)
  );

  // Next state: accept, issue one quarter per free cycle, and let
  // younger commit writes cancel their pending clear bit.
  always_comb begin
    state_d       = state_q;
    pend_d        = pend_q;
    done_d        = 1'b0;
    cap           = '0;
    issue         = 1'b0;
    req.req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req.req_ready = CHERI;
        if (CHERI && req.req_valid) begin
          cap = req.req_mask & ~32'h1;
          if (cm_we_i) cap[cm_waddr_i] = 1'b0;
          pend_d = cap;
          if (cap == '0) done_d  = 1'b1;
          else           state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (cm_we_i) begin
          pend_d[cm_waddr_i] = 1'b0;
          if (pend_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (q_valid) begin
          issue = 1'b1;
          pend_d[REGCLR_QW*q_quarter +: REGCLR_QW] = '0;
          if (q_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
    if (!CHERI) begin
      state_d = IDLE;
      pend_d  = '0;
      done_d  = 1'b0;
    end
  end

  // State, pending mask and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      pend_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  assign busy_o = (state_q == CLEAR);
  assign done_o = done_q;

  // Regfile port 0 mux: commit writes first, clears fill the gaps.
  always_comb begin
    rf_we_o      = cm_we_i;
    rf_waddr_o   = cm_waddr_i;
    rf_wdata_o   = cm_wdata_i;
    rf_clr_o     = 1'b0;
    rf_mask_o    = '0;
    rf_quarter_o = '0;
    if (issue) begin
      rf_we_o      = 1'b1;
      rf_waddr_o   = q_waddr;
      rf_wdata_o   = '0;
      rf_clr_o     = 1'b1;
      rf_mask_o    = q_mask;
      rf_quarter_o = q_quarter;
    end
  end

endmodule

// File: tb/tb_cheri_regclr_sequencer.sv
// Directed bench for the register-clear sequencer.
// Inputs change 1 ns after posedge; outputs are sampled at negedge.
module tb_cheri_regclr_sequencer;

  logic        clk;
  logic        rst_n;
  logic        busy, done;
  logic        cm_we;
  logic [4:0]  cm_waddr;
  logic [31:0] cm_wdata;
  logic        rf_we, rf_clr;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  rf_mask;
  logic [1:0]  rf_quarter;
  int          errors = 0;
  int          checks = 0;

  cheri_regclr_sequencer_if rif ();

  cheri_regclr_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req          (rif),
    .busy_o       (busy),
    .done_o       (done),
    .cm_we_i      (cm_we),
    .cm_waddr_i   (cm_waddr),
    .cm_wdata_i   (cm_wdata),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .rf_clr_o     (rf_clr),
    .rf_mask_o    (rf_mask),
    .rf_quarter_o (rf_quarter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic exp_clr(input string tag, input logic [1:0] q,
                         input logic [7:0] m, input logic [4:0] a);
    chk({tag, ".we"}, 32'(rf_we), 32'd1);
    chk({tag, ".clr"}, 32'(rf_clr), 32'd1);
    chk({tag, ".quarter"}, 32'(rf_quarter), 32'(q));
    chk({tag, ".mask"}, 32'(rf_mask), 32'(m));
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".wdata"}, rf_wdata, 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
  endtask

  task automatic exp_pass(input string tag, input logic [4:0] a,
                          input logic [31:0] d);
    chk({tag, ".we"}, 32'(rf_we), 32'd1);
    chk({tag, ".clr"}, 32'(rf_clr), 32'd0);
    chk({tag, ".mask"}, 32'(rf_mask), 32'd0);
    chk({tag, ".quarter"}, 32'(rf_quarter), 32'd0);
    chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".wdata"}, rf_wdata, d);
  endtask

  task automatic exp_idle(input string tag, input logic dn);
    chk({tag, ".done"}, 32'(done), 32'(dn));
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".ready"}, 32'(rif.req_ready), 32'd1);
    chk({tag, ".clr"}, 32'(rf_clr), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    rif.req_valid = 1'b0;
    rif.req_mask  = '0;
    cm_we         = 1'b0;
    cm_waddr      = '0;
    cm_wdata      = '0;

    smp();
    exp_idle("rst", 1'b0);
    chk("rst.mask", 32'(rf_mask), 32'd0);
    chk("rst.quarter", 32'(rf_quarter), 32'd0);
    nxt();
    rst_n = 1'b1;

    // two quarters, no commit traffic
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'h0000_0102;
    smp();
    chk("t1.ready", 32'(rif.req_ready), 32'd1);
    nxt();
    rif.req_valid = 1'b0;
    rif.req_mask  = '0;
    smp();
    exp_clr("t1.c1", 2'd0, 8'h02, 5'd1);
    chk("t1.c1.done", 32'(done), 32'd0);
    chk("t1.c1.ready", 32'(rif.req_ready), 32'd0);
    nxt();
    smp();
    exp_clr("t1.c2", 2'd1, 8'h01, 5'd8);
    chk("t1.c2.done", 32'(done), 32'd0);
    nxt();
    smp();
    exp_idle("t1.c3", 1'b1);
    chk("t1.c3.we", 32'(rf_we), 32'd0);
    nxt();
    smp();
    chk("t1.c4.done", 32'(done), 32'd0);

    // top quarter, commit holds the port for three cycles
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'hFF00_0000;
    nxt();
    rif.req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cm_we    = 1'b1;
      cm_waddr = 5'(3 + i);
      cm_wdata = 32'hA5A5_0000 + 32'(i);
      smp();
      exp_pass("t2.pass", 5'(3 + i), 32'hA5A5_0000 + 32'(i));
      chk("t2.pass.busy", 32'(busy), 32'd1);
      nxt();
    end
    cm_we = 1'b0;
    smp();
    exp_clr("t2.clr", 2'd3, 8'hFF, 5'd24);
    nxt();
    smp();
    exp_idle("t2.done", 1'b1);

    // younger commit writes cancel every pending clear
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'h0000_0030;
    nxt();
    rif.req_valid = 1'b0;
    cm_we    = 1'b1;
    cm_waddr = 5'd4;
    cm_wdata = 32'h1111_1111;
    smp();
    exp_pass("t3.w4", 5'd4, 32'h1111_1111);
    nxt();
    cm_waddr = 5'd5;
    cm_wdata = 32'h2222_2222;
    smp();
    exp_pass("t3.w5", 5'd5, 32'h2222_2222);
    nxt();
    cm_we = 1'b0;
    smp();
    exp_idle("t3.done", 1'b1);
    chk("t3.we", 32'(rf_we), 32'd0);
    nxt();
    smp();
    exp_idle("t3.after", 1'b0);

    // x0-only mask, then empty mask accepted in the done cycle
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'h0000_0001;
    nxt();
    rif.req_mask  = 32'h0000_0000;
    smp();
    exp_idle("t4.x0", 1'b1);
    nxt();
    rif.req_valid = 1'b0;
    smp();
    exp_idle("t4.zero", 1'b1);
    nxt();
    smp();
    exp_idle("t4.after", 1'b0);

    // accept while commit writes a masked register
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'h0000_0006;
    cm_we    = 1'b1;
    cm_waddr = 5'd1;
    cm_wdata = 32'h3333_3333;
    smp();
    exp_pass("t5.acc", 5'd1, 32'h3333_3333);
    nxt();
    rif.req_valid = 1'b0;
    cm_we = 1'b0;
    smp();
    exp_clr("t5.clr", 2'd0, 8'h04, 5'd2);
    nxt();
    smp();
    exp_idle("t5.done", 1'b1);

    // reset in the middle of a full clear
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'hFFFF_FFFF;
    nxt();
    rif.req_valid = 1'b0;
    smp();
    exp_clr("t6.q0", 2'd0, 8'hFE, 5'd1);
    nxt();
    smp();
    exp_clr("t6.q1", 2'd1, 8'hFF, 5'd8);
    nxt();
    rst_n = 1'b0;
    smp();
    exp_idle("t6.rst", 1'b0);
    nxt();
    rst_n = 1'b1;
    rif.req_valid = 1'b1;
    rif.req_mask  = 32'h0000_0010;
    nxt();
    rif.req_valid = 1'b0;
    smp();
    exp_clr("t6.new", 2'd0, 8'h10, 5'd4);
    nxt();
    smp();
    exp_idle("t6.done", 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
